cr_sa_snap_seq: RTL
===================

CR_SA_SNAP_SEQ -- requirements
Module: cr_sa_snap_seq

Interface
REQ-001 Parameter NUM_CTRS, default 8, number of cr_sa counters served (legal range 1..16).
REQ-002 Parameter DROP_W, default 16, width of the dropped-trigger counter.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 cfg_interval  in  32  periodic snapshot interval in clk cycles; 0 = timer disabled.
REQ-006 cfg_clear_on_snap  in  1  1 = pulse sa_clear together with sa_snap (read-and-clear).
REQ-007 snap_req  in  1  software snapshot request, single-cycle pulse.
REQ-008 sa_snapshot  in  NUM_CTRS x 50  snapshot values returned by the counters.
REQ-009 sa_snap  out  1  snapshot strobe broadcast to all counters.
REQ-010 sa_clear  out  1  clear strobe broadcast to all counters.
REQ-011 out_valid / out_ready  out / in  1 / 1  readout stream handshake.
REQ-012 out_data  out  64  {ctr_idx[7:0], 6'b0, count[49:0]}.
REQ-013 out_last  out  1  marks the record for index NUM_CTRS-1.
REQ-014 busy  out  1  high whenever the FSM is not IDLE.
REQ-015 drop_cnt  out  DROP_W  number of triggers discarded while busy, saturating.

Function
REQ-016 Trigger = snap_req OR timer expiry in the same cycle; simultaneous sources count as one trigger.
REQ-017 Timer: increments each cycle when cfg_interval != 0; expires and returns to 0 when timer >= cfg_interval-1; held at 0 when cfg_interval == 0.
REQ-018 FSM states: IDLE, SNAP, WAIT, DRAIN.
REQ-019 IDLE + trigger -> SNAP; otherwise stay in IDLE.
REQ-020 SNAP lasts exactly 1 cycle: sa_snap=1 and sa_clear=cfg_clear_on_snap; next state is WAIT.
REQ-021 WAIT lasts exactly 1 cycle, allowing the counter snapshot register to settle; idx is set to 0; next state is DRAIN.
REQ-022 DRAIN: out_valid=1 and out_data carries idx with sa_snapshot[idx]; out_last=(idx==NUM_CTRS-1).
REQ-023 While out_valid is high and out_ready is low, out_data and out_last shall be held stable.
REQ-024 On out_valid && out_ready: if out_last, go to IDLE; otherwise idx increments.
REQ-025 A trigger arriving in a state other than IDLE is discarded and increments drop_cnt, which saturates at all-ones.
REQ-026 The timer keeps running regardless of FSM state.
REQ-027 sa_snap and sa_clear are 0 in every state except SNAP.
REQ-028 out_valid is 0 in every state except DRAIN.
REQ-029 Snapshot-to-first-record latency: trigger at cycle T gives sa_snap at T+1 and out_valid at T+3.
REQ-030 Minimum sequence length with out_ready held high: NUM_CTRS+2 cycles from SNAP back to IDLE.

Reset
REQ-031 With rst_n=0 at a clock edge, the following shall be 0: state=IDLE, timer, idx, drop_cnt, sa_snap, sa_clear, out_valid, out_last, out_data, busy.
REQ-032 Reset asserted mid-DRAIN abandons the sequence; no record is emitted after reset and no sa_clear is issued.

Structure
REQ-033 The state enum and the out_data field widths/offsets shall be defined in the shared cr_structs package.
REQ-034 The interval timer shall be a separate sub-module, cr_sa_interval_tmr, with inputs cfg_interval and outputs an expiry pulse.
REQ-035 The readout mux shall be indexed directly by idx; no copy of the snapshot array is stored.

Verification
REQ-036 Reset then snap_req at cycle 10, NUM_CTRS=8, out_ready=1 -> sa_snap at 11, out_valid from 13 to 20, idx 0..7, out_last at 20 only.
REQ-037 cfg_clear_on_snap=1 -> sa_snap and sa_clear are both high for one cycle at SNAP; counter 3 holding 100 reads out 100 and restarts from 0.
REQ-038 out_ready toggling 1,0,0,1 during DRAIN -> out_data stable across stalls; records arrive in order with no duplicates or losses.
REQ-039 cfg_interval=5, out_ready=0 -> first trigger is accepted; later expiries every 5 cycles are dropped; drop_cnt=N after N dropped expiries, and saturates at 16'hFFFF.
REQ-040 snap_req coincident with timer expiry in IDLE -> exactly one sequence; drop_cnt unchanged.
REQ-041 rst_n=0 at idx=4 in DRAIN -> next cycle state=IDLE, all outputs 0, and no further records.

Source files
------------

// File: rtl/cr_sa_snap_seq_pkg.sv
// Shared types for the cr_sa snapshot sequencer: FSM states and readout record layout.
package cr_structs;

   localparam int unsigned CNT_W  = 50;
   localparam int unsigned IDX_W  = 8;
   localparam int unsigned PAD_W  = 6;
   localparam int unsigned DATA_W = IDX_W + PAD_W + CNT_W;
   localparam int unsigned TMR_W  = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SNAP  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } snap_state_e;

   // Readout record: idx in [63:56], zero pad in [55:50], count in [49:0]
   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [PAD_W-1:0] pad;
      logic [CNT_W-1:0] count;
   } snap_rec_t;

   function automatic snap_rec_t make_rec(input logic [IDX_W-1:0] idx,
                                          input logic [CNT_W-1:0] count);
      snap_rec_t r;
      r.idx   = idx;
      r.pad   = '0;
      r.count = count;
      return r;
   endfunction

endpackage

// File: rtl/cr_sa_snap_seq_if.sv
// Readout stream between the snapshot sequencer and its consumer.
interface cr_sa_snap_seq_if;
   import cr_structs::*;

   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic [DATA_W-1:0] out_data;

   modport master (output out_valid, output out_data, output out_last, input out_ready);
   modport slave  (input out_valid, input out_data, input out_last, output out_ready);

endinterface

// File: rtl/cr_sa_interval_tmr.sv
// Free-running interval timer; expire_c pulses once every cfg_interval cycles (0 = off).
module cr_sa_interval_tmr
   import cr_structs::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [TMR_W-1:0] cfg_interval,
   output logic             expire_c
);

   logic [TMR_W-1:0] timer_q;
   logic [TMR_W-1:0] timer_d;

   // Count up, wrap to 0 on expiry; held at 0 while disabled
   always_comb begin
      timer_d  = timer_q;
      expire_c = 1'b0;
      if (cfg_interval == '0) begin
         timer_d = '0;
      end else if (timer_q >= cfg_interval - TMR_W'(1)) begin
         timer_d  = '0;
         expire_c = 1'b1;
      end else begin
         timer_d = timer_q + TMR_W'(1);
      end
   end

   // Timer register
   always_ff @(posedge clk) begin
      if (!rst_n) timer_q <= '0;
      else        timer_q <= timer_d;
   end

endmodule

// File: rtl/cr_sa_snap_seq.sv
// Snapshot sequencer: strobes all cr_sa counters, then streams their snapshots out one record each.
module cr_sa_snap_seq
   import cr_structs::*;
#(
   parameter int unsigned NUM_CTRS = 8,
   parameter int unsigned DROP_W   = 16
)(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [TMR_W-1:0]                 cfg_interval,
   input  logic                             cfg_clear_on_snap,
   input  logic                             snap_req,
   input  logic [NUM_CTRS-1:0][CNT_W-1:0]   sa_snapshot,
   output logic                             sa_snap,
   output logic                             sa_clear,
   output logic                             busy,
   output logic [DROP_W-1:0]                drop_cnt,
   cr_sa_snap_seq_if.master                 ro
);

   localparam int unsigned    SEL_W    = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CTRS - 1);

   snap_state_e      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic             sa_snap_q, sa_snap_d;
   logic             sa_clear_q, sa_clear_d;
   logic             busy_q, busy_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   snap_rec_t        out_data_q, out_data_d;

   logic             tmr_expire_c;
   logic             trig_c;
   logic             hs_c;

   cr_sa_interval_tmr u_tmr (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_interval (cfg_interval),
      .expire_c     (tmr_expire_c)
   );

   // Simultaneous software and timer requests merge into one trigger
   assign trig_c = snap_req | tmr_expire_c;
   assign hs_c   = out_valid_q & ro.out_ready;

   // Next state, drop accounting and registered outputs derived from the next state
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      drop_d     = drop_q;
      out_data_d = out_data_q;

      if (trig_c && (state_q != ST_IDLE) && (drop_q != '1)) begin
         drop_d = drop_q + DROP_W'(1);
      end

      case (state_q)
         ST_IDLE:  if (trig_c) state_d = ST_SNAP;
         ST_SNAP:  state_d = ST_WAIT;
         ST_WAIT: begin
            state_d = ST_DRAIN;
            idx_d   = '0;
         end
         ST_DRAIN: begin
            if (hs_c) begin
               if (out_last_q) state_d = ST_IDLE;
               else            idx_d   = idx_q + IDX_W'(1);
            end
         end
         default:  state_d = ST_IDLE;
      endcase

      sa_snap_d   = (state_d == ST_SNAP);
      sa_clear_d  = sa_snap_d & cfg_clear_on_snap;
      busy_d      = (state_d != ST_IDLE);
      out_valid_d = (state_d == ST_DRAIN);
      out_last_d  = out_valid_d && (idx_d == LAST_IDX);

      // Load a record on entry to DRAIN or after each accepted beat; hold it across stalls
      if (!out_valid_d) begin
         out_data_d = '0;
      end else if (!out_valid_q || hs_c) begin
         out_data_d = make_rec(idx_d, sa_snapshot[SEL_W'(idx_d)]);
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         drop_q      <= '0;
         sa_snap_q   <= 1'b0;
         sa_clear_q  <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         drop_q      <= drop_d;
         sa_snap_q   <= sa_snap_d;
         sa_clear_q  <= sa_clear_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   assign sa_snap      = sa_snap_q;
   assign sa_clear     = sa_clear_q;
   assign busy         = busy_q;
   assign drop_cnt     = drop_q;
   assign ro.out_valid = out_valid_q;
   assign ro.out_last  = out_last_q;
   assign ro.out_data  = out_data_q;

endmodule
